// File: rtl/sap_controller_sequencer_if.sv
// Control-word bundle between the SAP sequencer and the datapath it steers.
interface sap_controller_sequencer_if;
  logic [3:0] opcode;
  logic       carry;
  logic       zero;
  logic       cp, ep, lp, lm, ce, li, ei, la, ea, su, eu, lb, lo;
  logic       hlt;
  logic [5:0] t_state;

  modport master (
    input  opcode, carry, zero,
    output cp, ep, lp, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt, t_state
  );

  modport slave (
    output opcode, carry, zero,
    input  cp, ep, lp, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt, t_state
  );
endinterface

// File: rtl/sap_controller_sequencer.sv
// SAP CPU sequencer: six-state one-hot T-ring with opcode decode into the
// datapath control word, plus a sticky halt register that only clr clears.
module sap_controller_sequencer (
  input  logic                          clk,
  input  logic                          clr,
  sap_controller_sequencer_if.master    bus
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_JC  = 4'b0100;
  localparam logic [3:0] OP_JZ  = 4'b0101;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  t_state_e state, state_next;
  logic     halt, halt_next;

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= T1;
      halt  <= 1'b0;
    end else begin
      state <= state_next;
      halt  <= halt_next;
    end
  end

  // Halt sets on the edge ending T4, so the frozen state is always T5.
  always_comb begin
    state_next = state;
    halt_next  = halt;
    if (!halt) begin
      case (state)
        T1: state_next = T2;
        T2: state_next = T3;
        T3: state_next = T4;
        T4: begin
          state_next = T5;
          if (bus.opcode == OP_HLT) halt_next = 1'b1;
        end
        T5: state_next = T6;
        T6: state_next = T1;
        default: state_next = T1;
      endcase
    end
  end

  always_comb begin
    bus.cp = 1'b0;
    bus.ep = 1'b0;
    bus.lp = 1'b0;
    bus.lm = 1'b0;
    bus.ce = 1'b0;
    bus.li = 1'b0;
    bus.ei = 1'b0;
    bus.la = 1'b0;
    bus.ea = 1'b0;
    bus.su = 1'b0;
    bus.eu = 1'b0;
    bus.lb = 1'b0;
    bus.lo = 1'b0;
    if (!clr && !halt) begin
      case (state)
        T1: begin bus.ep = 1'b1; bus.lm = 1'b1; end
        T2: bus.cp = 1'b1;
        T3: begin bus.ce = 1'b1; bus.li = 1'b1; end
        T4: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB: begin bus.ei = 1'b1; bus.lm = 1'b1; end
            OP_JMP: begin bus.ei = 1'b1; bus.lp = 1'b1; end
            OP_JC:  begin bus.ei = bus.carry; bus.lp = bus.carry; end
            OP_JZ:  begin bus.ei = bus.zero;  bus.lp = bus.zero;  end
            OP_OUT: begin bus.ea = 1'b1; bus.lo = 1'b1; end
            default: ;
          endcase
        end
        T5: begin
          case (bus.opcode)
            OP_LDA:         begin bus.ce = 1'b1; bus.la = 1'b1; end
            OP_ADD, OP_SUB: begin bus.ce = 1'b1; bus.lb = 1'b1; end
            default: ;
          endcase
        end
        T6: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            bus.eu = 1'b1;
            bus.la = 1'b1;
            bus.su = (bus.opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hlt     = halt;
  assign bus.t_state = clr ? T1 : state;

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Directed-vector bench for the SAP sequencer, plus a random invariant soak.
module tb_sap_controller_sequencer;

  logic clk;
  logic clr;
  sap_controller_sequencer_if bus ();

  sap_controller_sequencer dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe word layout: {cp,ep,lp,lm,ce,li,ei,la,ea,su,eu,lb,lo,hlt}
  localparam logic [13:0] CP  = 14'b10000000000000;
  localparam logic [13:0] EP  = 14'b01000000000000;
  localparam logic [13:0] LP  = 14'b00100000000000;
  localparam logic [13:0] LM  = 14'b00010000000000;
  localparam logic [13:0] CE  = 14'b00001000000000;
  localparam logic [13:0] LI  = 14'b00000100000000;
  localparam logic [13:0] EI  = 14'b00000010000000;
  localparam logic [13:0] LA  = 14'b00000001000000;
  localparam logic [13:0] EA  = 14'b00000000100000;
  localparam logic [13:0] SU  = 14'b00000000010000;
  localparam logic [13:0] EU  = 14'b00000000001000;
  localparam logic [13:0] LB  = 14'b00000000000100;
  localparam logic [13:0] LO  = 14'b00000000000010;
  localparam logic [13:0] HLT = 14'b00000000000001;
  localparam logic [13:0] NONE = 14'b0;

  localparam logic [5:0] S1 = 6'b000001, S2 = 6'b000010, S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000, S5 = 6'b010000, S6 = 6'b100000;

  int test_count = 0;
  int fail_count = 0;

  function automatic logic [19:0] observe();
    return {bus.t_state, bus.cp, bus.ep, bus.lp, bus.lm, bus.ce, bus.li, bus.ei,
            bus.la, bus.ea, bus.su, bus.eu, bus.lb, bus.lo, bus.hlt};
  endfunction

  task automatic checkOutput(input string tag, input logic [19:0] observed,
                             input logic [19:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs, check the settled control word, then step the clock.
  task automatic applyStimulus(input logic [3:0] op, input logic c, input logic z,
                               input logic clr_v, input string tag,
                               input logic [5:0] t_exp, input logic [13:0] s_exp);
    bus.opcode = op;
    bus.carry  = c;
    bus.zero   = z;
    clr        = clr_v;
    #1;
    checkOutput(tag, observe(), {t_exp, s_exp});
    @(posedge clk);
    #1;
  endtask

  task automatic runInstr(input logic [3:0] op, input logic c, input logic z,
                          input string name, input logic [13:0] e4,
                          input logic [13:0] e5, input logic [13:0] e6);
    applyStimulus(op, c, z, 1'b0, {name, "_t1"}, S1, EP | LM);
    applyStimulus(op, c, z, 1'b0, {name, "_t2"}, S2, CP);
    applyStimulus(op, c, z, 1'b0, {name, "_t3"}, S3, CE | LI);
    applyStimulus(op, c, z, 1'b0, {name, "_t4"}, S4, e4);
    applyStimulus(op, c, z, 1'b0, {name, "_t5"}, S5, e5);
    applyStimulus(op, c, z, 1'b0, {name, "_t6"}, S6, e6);
  endtask

  initial begin
    bus.opcode = 4'b0001;
    bus.carry  = 1'b0;
    bus.zero   = 1'b0;
    clr        = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b1, "reset", S1, NONE);

    runInstr(4'b0001, 1'b0, 1'b0, "add", EI | LM, CE | LB, EU | LA);

    // Abort ADD at T5 with a one-cycle clr, then restart the fetch.
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, "mid_t1", S1, EP | LM);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, "mid_t2", S2, CP);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, "mid_t3", S3, CE | LI);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, "mid_t4", S4, EI | LM);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b1, "mid_clr", S1, NONE);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, "mid_restart", S1, EP | LM);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, "mid_t2_again", S2, CP);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b1, "mid_clr2", S1, NONE);

    runInstr(4'b0010, 1'b0, 1'b0, "sub", EI | LM, CE | LB, SU | EU | LA);
    runInstr(4'b0000, 1'b0, 1'b0, "lda", EI | LM, CE | LA, NONE);
    runInstr(4'b0011, 1'b0, 1'b0, "jmp", EI | LP, NONE, NONE);
    runInstr(4'b0100, 1'b0, 1'b1, "jc_c0", NONE, NONE, NONE);
    runInstr(4'b0100, 1'b1, 1'b0, "jc_c1", EI | LP, NONE, NONE);
    runInstr(4'b0101, 1'b1, 1'b0, "jz_z0", NONE, NONE, NONE);
    runInstr(4'b0101, 1'b0, 1'b1, "jz_z1", EI | LP, NONE, NONE);
    runInstr(4'b1010, 1'b1, 1'b1, "nop", NONE, NONE, NONE);
    runInstr(4'b1110, 1'b0, 1'b0, "out", EA | LO, NONE, NONE);

    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, "hlt_t1", S1, EP | LM);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, "hlt_t2", S2, CP);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, "hlt_t3", S3, CE | LI);
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, "hlt_t4", S4, NONE);
    for (int i = 0; i < 20; i++)
      applyStimulus(4'b0001, 1'b1, 1'b1, 1'b0, "halted", S5, HLT);

    clr = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b1, "hlt_clr", S1, NONE);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, "hlt_resume", S1, EP | LM);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, "hlt_resume_t2", S2, CP);

    // Random soak: each cycle must respect the bus, load and one-hot invariants.
    for (int i = 0; i < 10000; i++) begin
      logic ok;
      bus.opcode = 4'($urandom);
      bus.carry  = 1'($urandom);
      bus.zero   = 1'($urandom);
      clr        = ($urandom_range(0, 31) == 0);
      #1;
      ok = ($countones({bus.ep, bus.ce, bus.ei, bus.ea, bus.eu}) <= 1)
           && !(bus.cp && bus.lp)
           && $onehot(bus.t_state)
           && !(bus.su && !bus.eu);
      checkOutput("soak_inv", {19'b0, ok}, 20'd1);
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/sap_controller_sequencer.md
# sap_controller_sequencer

Control sequencer for the 4-bit-address SAP CPU. It runs a fixed six-state T-cycle ring, decodes the 4-bit opcode from the instruction register, and drives the control word for every datapath stage. That control word includes cp/ep/lp for the program counter directly downstream. While the CPU is running, it is the only source of bus-enable and register-load strobes.

## Interface
Parameters:
- None; T-state count (6) and opcode map are fixed.

Ports:
- clk  in  1  rising-edge clock; all state changes on this edge only
- clr  in  1  reset; synchronous, active-high: sampled on rising clk, forces state to T1, clears halt
- opcode  in  4  instruction register upper nibble; valid from T4 onward
- carry  in  1  carry flag from flag register
- zero  in  1  zero flag from flag register
- cp  out  1  program counter count enable
- ep  out  1  program counter drive bus
- lp  out  1  program counter load from bus
- lm  out  1  MAR load
- ce  out  1  RAM drive bus
- li  out  1  instruction register load
- ei  out  1  instruction register operand nibble drive bus
- la  out  1  A register load
- ea  out  1  A register drive bus
- su  out  1  ALU subtract select
- eu  out  1  ALU drive bus
- lb  out  1  B register load
- lo  out  1  output register load
- hlt  out  1  halted indicator; stops instruction fetch
- t_state  out  6  one-hot current T-state; bit0 = T1

## Operation
- State is a one-hot ring T1→T2→T3→T4→T5→T6→T1. It advances one step per rising clk.
- Every instruction takes exactly 6 cycles. There is no early exit.
- All control outputs are combinational decodes of registered state, opcode, carry and zero.
- The control word is stable for the whole cycle. Downstream registers capture it on the rising edge that ends the cycle.
- Fetch cycle, independent of opcode:
  - T1: ep, lm
  - T2: cp
  - T3: ce, li
- Execute cycle (T4 / T5 / T6):
  - LDA 0000: T4 ei,lm; T5 ce,la; T6 none
  - ADD 0001: T4 ei,lm; T5 ce,lb; T6 eu,la
  - SUB 0010: T4 ei,lm; T5 ce,lb; T6 su,eu,la
  - JMP 0011: T4 ei,lp; T5 none; T6 none
  - JC 0100: T4 ei,lp only if carry=1; otherwise none
  - JZ 0101: T4 ei,lp only if zero=1; otherwise none
  - OUT 1110: T4 ea,lo; T5 none; T6 none
  - HLT 1111: T4 sets the halt register
  - All other opcodes are NOP: no execute strobes
- Halt:
  - The halt register is set on the rising edge ending T4 of HLT.
  - Once set, the state freezes at T5 and all strobes except hlt are 0.
  - hlt=1 only once the halt register is set. It is not asserted combinationally during T4.
  - Only clr exits halt.
- Bus-drive invariant: at most one of ep, ce, ei, ea, eu is 1 in any cycle.
- Load invariant: cp and lp are never both 1.
- su is meaningful only while eu=1; it is 0 otherwise.

## Timing
- Reset:
  - On a rising edge with clr=1, the state becomes T1 and halt clears.
  - While clr is high, all strobes are forced to 0 and t_state=000001.
  - On the first edge with clr=0, the ring starts: that cycle is T1 with ep=lm=1.
- clr takes priority over everything, including halt and mid-instruction states.
- clr asserted during any T-state aborts the instruction. No further strobes are issued until T1 after release.
- opcode must be stable from the edge ending T3 through T6. Changes during T1–T3 are ignored.
- carry and zero are sampled combinationally during T4 only.
- Wrap: T6 → T1 with no idle cycle. The fetch of the next instruction starts immediately.
- Latency: PC increments at the end of T2. A taken jump loads the PC at the end of T4; the next fetch uses the new address in T1.

## Test plan
- Reset mid-instruction:
  - Stimulus: run to T5 of ADD, assert clr for 1 cycle.
  - Required: t_state=000001 and all strobes 0 while clr=1.
  - Required: the next cycle shows ep=lm=1.
- Fetch/execute ADD:
  - Stimulus: opcode=0001, clr released.
  - Required, cycles 1–6: {ep,lm}, {cp}, {ce,li}, {ei,lm}, {ce,lb}, {eu,la}; cycle 7 = {ep,lm}.
- SUB vs ADD:
  - Stimulus: opcode=0010.
  - Required: T6 asserts su=eu=la=1; su=0 in all other cycles.
- Conditional jumps:
  - Stimulus: JC with carry=0, then carry=1.
  - Required: T4 is {} then {ei,lp}.
  - Repeat for JZ with zero.
  - Stimulus: opcode 1010.
  - Required: T4–T6 all 0.
- Halt:
  - Stimulus: OUT (0x E) followed by HLT (0xF).
  - Required: lo pulses in T4 of OUT.
  - Required: after T4 of HLT, hlt=1, t_state=010000, and all strobes stay 0 for 20 cycles.
  - Required: after clr, hlt=0 and the ring resumes at T1.
- Random soak:
  - Stimulus: 10k cycles with random opcode, carry and zero.
  - Required: the one-bus-driver invariant holds; cp&lp is never 1; t_state is always one-hot.
